phase_timer: RTL and testbench
==============================

# phase_timer

Parametrised multi-threshold interval timer for the traffic and emergency light controller. It is the successor to the fixed two-threshold timer. The timer counts prescaled ticks from a synchronous restart. It compares the count against NUM_THR run-time-programmable thresholds and reports each threshold as a level flag and as a one-cycle rising pulse. It adds pause, saturation and an auto-reload periodic mode, so the light FSM can time every phase (green, yellow, all-red, emergency hold) from one instance.

## Interface
- WIDTH, 16: count and threshold width in bits (≥ 2).
- NUM_THR, 4: number of thresholds (≥ 1). Threshold NUM_THR-1 is the "top" threshold used for auto-reload.
- PRESCALE, 1: Clk cycles per count tick (≥ 1).

- Clk  in  1  rising-edge clock; the block uses one clock only.
- Rst  in  1  reset, asynchronous, active-high.
- ST  in  1  synchronous restart: count and prescaler go to 0; dominates En and Auto.
- En  in  1  count enable; 0 = pause (count and prescaler hold).
- Auto  in  1  periodic mode: reload to 0 when the top threshold is reached.
- Thr  in  NUM_THR*WIDTH  thresholds, unsigned; Thr[i] = bits [i*WIDTH +: WIDTH].
- Value  out  WIDTH  current count (registered).
- TF  out  NUM_THR  level flags: TF[i] = (Value >= Thr[i]), combinational.
- TP  out  NUM_THR  rising pulse: TP[i] = TF[i] & ~tf_q[i], combinational.
- Sat  out  1  Value == 2^WIDTH-1, combinational.
- Wrap  out  1  registered one-cycle pulse on auto-reload.

## Operation
- State registers: Value, prescaler pre (0..PRESCALE-1, width clog2(PRESCALE), min 1 bit), tf_q (NUM_THR), Wrap.
- Tick: tick = En & ~ST & (pre == PRESCALE-1).
- Prescaler:
  - ST → pre = 0.
  - Else if En: pre = 0 on tick, otherwise pre+1.
  - Else pre holds.
- Count update, in priority order at each edge:
  1. ST → Value = 0.
  2. tick & Auto & (Value >= Thr[NUM_THR-1]) → Value = 0, Wrap = 1.
  3. tick & Value != max → Value+1.
  4. Otherwise Value holds. Saturation at max holds Value and keeps Sat high.
- Wrap is 0 in every cycle not covered by rule 2.
- Compares are unsigned, full WIDTH. There is no overflow wrap except through Auto.
- tf_q is TF registered every cycle; it is not gated by En.
- Consequences of the pulse definition (accepted behaviour):
  - A Thr change that raises TF produces a TP pulse.
  - A threshold of 0 never pulses after reset.
  - After a restart or wrap, TP[i] fires again when Value re-crosses Thr[i].
- Auto with top threshold 0: Value stays 0 and Wrap pulses on every tick.
- Auto deasserted mid-count: counting continues past the top threshold toward saturation.
- Simultaneous ST and tick at the top threshold: ST wins; Value = 0 and Wrap = 0.

## Timing
- Reset values: Value = 0, pre = 0, Wrap = 0, tf_q = all ones. During and after reset, TP = 0 and TF = (0 >= Thr).
- Rst asserted mid-count clears the count immediately (asynchronous). Counting resumes on the first edge with Rst low.
- ST high at edge k → Value = 0 after edge k.
- With PRESCALE = 1 and En held high, Value = n after the n-th edge following the last ST-high edge.
- With prescaling, Value increments on every PRESCALE-th enabled edge after restart. The first increment comes PRESCALE enabled edges after ST.
- TF[i] rises in the same cycle Value reaches Thr[i]. TP[i] is high for exactly that one cycle (zero latency after the count edge).
- Wrap is high in the cycle after the reload edge, aligned with Value = 0.
- Pause: with En = 0, Value and pre freeze. When En returns, counting resumes with no lost or extra ticks.

## Test plan
- Reset, then a ST pulse, then Thr = {8,5,3,1}, PRESCALE = 1, En = 1, Auto = 0 → Value counts 0,1,2,…; TP[0] at Value = 1, TP[1] at 3, TP[2] at 5, TP[3] at 8, each high for one cycle; TF stays high afterward.
- PRESCALE = 3, En = 1, 12 edges after ST → Value = 4. Drop En for 5 edges, then re-enable → Value holds at 4, then reaches 5 exactly 3 enabled edges after re-enable.
- WIDTH = 4, Auto = 0, run 20 edges → Value saturates at 15, Sat = 1, no Wrap.
- Auto = 1, Thr[top] = 4 → Value sequence 0,1,2,3,4,0,1,…; Wrap is high for one cycle aligned with each 0 after 4; TP[top] fires once per period.
- Assert ST on the same edge as the top-threshold tick in Auto → Value = 0, Wrap = 0. Assert Rst asynchronously mid-count (between edges) → Value = 0 immediately, TP = 0.

Source files
------------

// File: rtl/phase_timer_if.sv
// phase_timer_if: control and status bundle for phase_timer.
//   st      restart request (count and prescaler to 0)
//   en      count enable (0 = pause)
//   auto_en periodic mode, reload at the top threshold
//   thr     packed thresholds, thr[i*WIDTH +: WIDTH]
//   value   current count
//   tf      per-threshold level flags
//   tp      per-threshold rising pulses
//   sat     count is at its maximum
//   wrap    one-cycle pulse after an auto-reload
// master drives the controls and reads the status; slave is the timer side.
interface phase_timer_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_THR = 4
);
  logic                       st;
  logic                       en;
  logic                       auto_en;
  logic [NUM_THR*WIDTH-1:0]   thr;
  logic [WIDTH-1:0]           value;
  logic [NUM_THR-1:0]         tf;
  logic [NUM_THR-1:0]         tp;
  logic                       sat;
  logic                       wrap;

  modport master (
    output st, en, auto_en, thr,
    input  value, tf, tp, sat, wrap
  );

  modport slave (
    input  st, en, auto_en, thr,
    output value, tf, tp, sat, wrap
  );
endinterface

// File: rtl/phase_timer.sv
// phase_timer: multi-threshold interval timer with prescaler, pause,
// saturation and auto-reload (periodic) mode.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  phase_timer_if slave: st/en/auto_en/thr in, value/tf/tp/sat/wrap out
// Threshold NUM_THR-1 is the top threshold used for auto-reload.
module phase_timer #(
  parameter int WIDTH    = 16,
  parameter int NUM_THR  = 4,
  parameter int PRESCALE = 1
) (
  input  logic          clk,
  input  logic          rst,
  phase_timer_if.slave  bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] VALUE_MAX = '1;

  logic [WIDTH-1:0]   value_q;
  logic [PW-1:0]      pre_q;
  logic [NUM_THR-1:0] tf;
  logic [NUM_THR-1:0] tf_q;
  logic               wrap_q;
  logic               tick;
  logic               top_hit;

  always_comb begin
    tf = '0;
    for (int i = 0; i < NUM_THR; i++) begin
      tf[i] = (value_q >= bus.thr[i*WIDTH +: WIDTH]);
    end
  end

  // The top level flag is exactly the reload condition.
  assign top_hit = tf[NUM_THR-1];
  assign tick    = bus.en & ~bus.st & (pre_q == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else if (bus.st) begin
      pre_q <= '0;
    end else if (bus.en) begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.st) begin
        value_q <= '0;
      end else if (tick && bus.auto_en && top_hit) begin
        value_q <= '0;
        wrap_q  <= 1'b1;
      end else if (tick && (value_q != VALUE_MAX)) begin
        value_q <= value_q + WIDTH'(1);
      end
    end
  end

  // Reset to all ones so thresholds already met at reset (e.g. 0) do not pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tf_q <= '1;
    end else begin
      tf_q <= tf;
    end
  end

  assign bus.value = value_q;
  assign bus.tf    = tf;
  assign bus.tp    = tf & ~tf_q;
  assign bus.sat   = (value_q == VALUE_MAX);
  assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_phase_timer.sv
// tb_phase_timer: three phase_timer instances (16-bit/prescale 1,
// 16-bit/prescale 3, 4-bit/prescale 1) driven with shared controls and
// checked every cycle against a behavioural model.
module tb_phase_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st = 1'b0, en = 1'b0, auto_en = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phase_timer_if #(.WIDTH(16), .NUM_THR(4)) if0 ();
  phase_timer_if #(.WIDTH(16), .NUM_THR(4)) if1 ();
  phase_timer_if #(.WIDTH(4),  .NUM_THR(4)) if2 ();

  assign if0.st = st;  assign if0.en = en;  assign if0.auto_en = auto_en;
  assign if1.st = st;  assign if1.en = en;  assign if1.auto_en = auto_en;
  assign if2.st = st;  assign if2.en = en;  assign if2.auto_en = auto_en;

  phase_timer #(.WIDTH(16), .NUM_THR(4), .PRESCALE(1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  phase_timer #(.WIDTH(16), .NUM_THR(4), .PRESCALE(3)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  phase_timer #(.WIDTH(4),  .NUM_THR(4), .PRESCALE(1)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // Reference model: count, prescaler phase, previous flags, wrap per instance.
  int       pres [3] = '{1, 3, 1};
  int       maxv [3] = '{65535, 65535, 15};
  int       mval [3];
  int       mpre [3];
  int       mwrap[3];
  bit [3:0] mtfq [3];
  int       mthr [3][4];

  function automatic bit [3:0] model_tf(int d);
    bit [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (mval[d] >= mthr[d][i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mval[d] = 0; mpre[d] = 0; mwrap[d] = 0; mtfq[d] = 4'hF;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      bit tick;
      tick = en && !st && (mpre[d] == pres[d] - 1);
      mtfq[d]  = model_tf(d);
      mwrap[d] = 0;
      if (st) mval[d] = 0;
      else if (tick && auto_en && mval[d] >= mthr[d][3]) begin
        mval[d] = 0; mwrap[d] = 1;
      end else if (tick && mval[d] != maxv[d]) mval[d] = mval[d] + 1;
      if (st) mpre[d] = 0;
      else if (en) mpre[d] = tick ? 0 : mpre[d] + 1;
    end
  endtask

  task automatic set_thr(int t3, int t2, int t1, int t0);
    int t[4];
    t = '{t0, t1, t2, t3};
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 4; i++) mthr[d][i] = (d == 2) ? (t[i] & 15) : t[i];
    if0.thr = {16'(t3), 16'(t2), 16'(t1), 16'(t0)};
    if1.thr = {16'(t3), 16'(t2), 16'(t1), 16'(t0)};
    if2.thr = {4'(t3), 4'(t2), 4'(t1), 4'(t0)};
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(int d, logic [31:0] v, logic [3:0] tf, logic [3:0] tp,
                           logic s, logic w);
    bit [3:0] etf;
    etf = model_tf(d);
    check($sformatf("d%0d value", d), v, 32'(mval[d]));
    check($sformatf("d%0d tf", d), 32'(tf), 32'(etf));
    check($sformatf("d%0d tp", d), 32'(tp), 32'(etf & ~mtfq[d]));
    check($sformatf("d%0d sat", d), 32'(s), 32'(mval[d] == maxv[d]));
    check($sformatf("d%0d wrap", d), 32'(w), 32'(mwrap[d]));
  endtask

  task automatic check_all();
    check_dut(0, 32'(if0.value), if0.tf, if0.tp, if0.sat, if0.wrap);
    check_dut(1, 32'(if1.value), if1.tf, if1.tp, if1.sat, if1.wrap);
    check_dut(2, 32'(if2.value), if2.tf, if2.tp, if2.sat, if2.wrap);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int top_steps;
    model_reset();
    set_thr(8, 5, 3, 1);
    #12;
    check_all();
    check("reset tp", 32'(if0.tp), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Restart then count through the thresholds.
    st = 1'b1; en = 1'b1;
    step();
    st = 1'b0;
    for (int k = 0; k < 12; k++) step();
    check("pre3 value after 12", 32'(if1.value), 32'd4);

    // Pause for 5 edges, then resume.
    en = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("pre3 value paused", 32'(if1.value), 32'd4);
    en = 1'b1;
    step(); step();
    check("pre3 value 2 after resume", 32'(if1.value), 32'd4);
    step();
    check("pre3 value 3 after resume", 32'(if1.value), 32'd5);

    // Saturation of the narrow instance.
    for (int k = 0; k < 20; k++) step();
    check("w4 saturated value", 32'(if2.value), 32'd15);
    check("w4 sat flag", 32'(if2.sat), 32'd1);

    // Periodic mode with top threshold 4.
    st = 1'b1;
    step();
    st = 1'b0; auto_en = 1'b1;
    set_thr(4, 3, 2, 1);
    for (int k = 0; k < 15; k++) step();

    // Restart coinciding with the top-threshold tick.
    top_steps = 0;
    while (mval[0] != 4 && top_steps < 20) begin
      step();
      top_steps++;
    end
    check("reach top before restart", 32'(if0.value), 32'd4);
    st = 1'b1;
    step();
    check("st beats reload value", 32'(if0.value), 32'd0);
    check("st beats reload wrap", 32'(if0.wrap), 32'd0);
    st = 1'b0;

    // Randomized operation.
    for (int k = 0; k < 300; k++) begin
      st = ($urandom_range(0, 15) == 0);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 19) == 0)
        set_thr($urandom_range(0, 20), $urandom_range(0, 20),
                $urandom_range(0, 20), $urandom_range(0, 20));
      step();
    end

    // Asynchronous reset between edges mid-count.
    st = 1'b0; en = 1'b1; auto_en = 1'b0;
    set_thr(8, 5, 3, 1);
    for (int k = 0; k < 4; k++) step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async rst value", 32'(if0.value), 32'd0);
    check("async rst tp", 32'(if0.tp), 32'd0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
